ahb_arbiter: RTL and testbench
==============================

// Module: ahb_arbiter
// PURPOSE
//   Two-master AHB bus arbiter. Produces hgrant_1/hgrant_2, which drive the write-path
//   master mux, plus hmaster/hmastlock for slaves. Fairness is round-robin with a
//   per-tenure beat limit. Locked transfers are honoured, and the bus parks on a
//   default master when idle.
// PARAMETERS
//   DEFAULT_MASTER  1   master parked on when no request (1 or 2)
//   MAX_BEATS       16  beats a master may issue before yielding to a requesting peer (>=1)
//   CNT_W           5   beat counter width, >= clog2(MAX_BEATS+1)
// PORTS
//   hclk       in   1  bus clock, rising edge
//   hresetn    in   1  asynchronous active-low reset
//   hbusreq_1  in   1  master 1 bus request
//   hbusreq_2  in   1  master 2 bus request
//   hlock_1    in   1  master 1 locked-transfer request
//   hlock_2    in   1  master 2 locked-transfer request
//   htrans     in   2  transfer type on the muxed bus (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   hready     in   1  muxed bus ready; all state advances only when high
//   hgrant_1   out  1  grant to master 1 (registered)
//   hgrant_2   out  1  grant to master 2 (registered)
//   hmaster    out  1  data-phase owner: 0 = master 1, 1 = master 2 (registered)
//   hmastlock  out  1  current transfer is locked (registered)
// BEHAVIOUR
// - Reset (hresetn=0, asynchronous):
//     hgrant_1 = (DEFAULT_MASTER==1), hgrant_2 = (DEFAULT_MASTER==2)
//     hmaster = DEFAULT_MASTER-1; hmastlock = 0; beat_cnt = 0.
// - Grant invariant: exactly one of hgrant_1/hgrant_2 is high in every cycle, reset included.
//   The mux's no-grant branch is therefore never exercised.
// - State machine: two states, OWN1 and OWN2, encoded directly as the grant registers.
//   OWN = currently granted master; PEER = the other master.
// - Decision order, evaluated on a rising edge with hready=1:
//     1. hlock_OWN=1                             -> stay; lock overrides beat limit
//     2. hbusreq_OWN=1 && beat_cnt<MAX_BEATS     -> stay
//     3. hbusreq_PEER=1                          -> switch to PEER
//     4. hbusreq_OWN=1                           -> stay (limit hit, no competition)
//     5. no requests                             -> go to DEFAULT_MASTER (park)
// - hready=0: grants, hmaster, hmastlock and beat_cnt all hold.
// - Latency:
//     grant change is visible 1 cycle after the deciding edge;
//     hmaster follows on the next hready=1 edge (hmaster <= index of current grant);
//     hmastlock <= hlock_OWN on each hready=1 edge.
// - beat_cnt:
//     cleared to 0 on any grant change;
//     else increments on hready=1 && htrans[1]=1 (NONSEQ/SEQ);
//     saturates at MAX_BEATS; BUSY/IDLE beats do not count.
// - Simultaneous requests from the park state:
//     the parked master is OWN and keeps the bus (rule 2);
//     PEER gains it after MAX_BEATS counted beats or when OWN drops its request.
// - Owner drops its request while PEER requests: switch on the same hready edge, whatever beat_cnt is.
// - Reset asserted mid-burst: all outputs go immediately to reset values; no partial tenure is remembered.
// TESTING
//   1. Reset release with DEFAULT_MASTER=1, no requests
//      -> hgrant_1=1, hgrant_2=0, hmaster=0, hmastlock=0, held for 10 cycles.
//   2. hbusreq_2=1 only, hready=1
//      -> hgrant_2=1 after 1 cycle, hmaster=1 one cycle later;
//      -> drop request -> bus returns to master 1 (park).
//   3. Both request; master 1 owns; htrans=NONSEQ then SEQ every cycle, MAX_BEATS=4
//      -> grant moves to master 2 after exactly 4 counted beats, then back after 4 more.
//   4. Master 1 owns with hlock_1=1 and hbusreq_2=1 for 20 beats
//      -> hgrant_1 stays 1, hmastlock=1;
//      -> deassert hlock_1 with beat_cnt>=MAX_BEATS -> switch to master 2 next edge.
//   5. Contention with hready=0 for 5 cycles at the switch point
//      -> grants/hmaster frozen; switch on first hready=1 edge.
//   6. Assert hresetn=0 mid-burst while master 2 owns
//      -> outputs reach reset values asynchronously, before the next hclk edge.
//   All: check one-hot grant invariant every cycle.

Source files
------------

// File: rtl/ahb_arbiter_if.sv
// Purpose: bundles the arbiter's request/grant signals for a two-master AHB arbiter.
// Latency: none; this file holds wiring only.
// Backpressure: hready is carried here, and the arbiter freezes all of its state while hready is low.
// Ports:
//   hbusreq_1/2, hlock_1/2  per-master request and locked-transfer request
//   htrans, hready          muxed-bus transfer type and ready
//   hgrant_1/2              registered grants, exactly one high at all times
//   hmaster, hmastlock      registered data-phase owner and lock indication
interface ahb_arbiter_if;
  logic       hbusreq_1;
  logic       hbusreq_2;
  logic       hlock_1;
  logic       hlock_2;
  logic [1:0] htrans;
  logic       hready;
  logic       hgrant_1;
  logic       hgrant_2;
  logic       hmaster;
  logic       hmastlock;

  // The arbiter takes the slave view: it receives requests and produces grants.
  modport slave (
    input  hbusreq_1, hbusreq_2, hlock_1, hlock_2, htrans, hready,
    output hgrant_1, hgrant_2, hmaster, hmastlock
  );

  // The master view belongs to the requesters and bus logic that drive the arbiter.
  modport master (
    output hbusreq_1, hbusreq_2, hlock_1, hlock_2, htrans, hready,
    input  hgrant_1, hgrant_2, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Purpose: two-master round-robin AHB arbiter with a per-tenure beat limit, lock and park.
// Latency: a grant changes 1 cycle after the deciding edge; hmaster follows on the next hready edge.
// Backpressure: while hready=0, the grants, hmaster, hmastlock and beat count all hold.
// Ports:
//   hclk     bus clock, rising edge
//   hresetn  asynchronous active-low reset
//   bus      ahb_arbiter_if.slave: requests, locks, htrans and hready in; grants, hmaster and hmastlock out
module ahb_arbiter #(
  parameter int DEFAULT_MASTER = 1,
  parameter int MAX_BEATS      = 16,
  parameter int CNT_W          = 5
) (
  input  logic          hclk,
  input  logic          hresetn,
  ahb_arbiter_if.slave  bus
);

  // Each state is the grant vector itself, so the grants come straight from flops.
  typedef enum logic [1:0] {
    OWN1 = 2'b01,
    OWN2 = 2'b10
  } state_t;

  localparam state_t            PARK  = (DEFAULT_MASTER == 2) ? OWN2 : OWN1;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(MAX_BEATS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_hmaster;
  logic             r_hmastlock;

  logic             w_own2;
  logic             w_lock_own;
  logic             w_req_own;
  logic             w_req_peer;
  logic             w_beat;

  // Route the signals so they read as owner and peer rather than master 1 and master 2.
  assign w_own2     = (r_state == OWN2);
  assign w_lock_own = w_own2 ? bus.hlock_2   : bus.hlock_1;
  assign w_req_own  = w_own2 ? bus.hbusreq_2 : bus.hbusreq_1;
  assign w_req_peer = w_own2 ? bus.hbusreq_1 : bus.hbusreq_2;
  // Only NONSEQ and SEQ transfers count toward the tenure limit.
  assign w_beat     = (bus.htrans == 2'b10) || (bus.htrans == 2'b11);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= PARK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The tests run in priority order: lock, then owner under its limit, then the
  // peer, then the owner alone, then park.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.hready) begin
      if (w_lock_own) begin
        w_state_nxt = r_state;
      end else if (w_req_own && (r_beat_cnt < LIMIT)) begin
        w_state_nxt = r_state;
      end else if (w_req_peer) begin
        w_state_nxt = w_own2 ? OWN1 : OWN2;
      end else if (w_req_own) begin
        w_state_nxt = r_state;
      end else begin
        w_state_nxt = PARK;
      end
    end
  end

  // hmaster and hmastlock describe the transfer that was granted before this edge.
  // They therefore sample the current owner, not the next one.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_beat_cnt  <= '0;
      r_hmaster   <= (DEFAULT_MASTER == 2);
      r_hmastlock <= 1'b0;
    end else if (bus.hready) begin
      r_hmaster   <= w_own2;
      r_hmastlock <= w_lock_own;
      if (w_state_nxt != r_state) begin
        r_beat_cnt <= '0;
      end else if (w_beat && (r_beat_cnt < LIMIT)) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.hgrant_1  = r_state[0];
  assign bus.hgrant_2  = r_state[1];
  assign bus.hmaster   = r_hmaster;
  assign bus.hmastlock = r_hmastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;
  localparam int DEF  = 1;
  localparam int MAXB = 4;

  logic hclk    = 1'b0;
  logic hresetn = 1'b1;

  ahb_arbiter_if bus();

  ahb_arbiter #(
    .DEFAULT_MASTER(DEF),
    .MAX_BEATS     (MAXB),
    .CNT_W         (3)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  // Reference state: owner number (1 or 2), counted beats, data-phase owner and lock.
  int m_owner;
  int m_beats;
  int m_hmaster;
  int m_mlock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = DEF;
    m_beats   = 0;
    m_hmaster = DEF - 1;
    m_mlock   = 0;
  endtask

  // Apply one rising edge to the reference model, using the inputs present at that edge.
  task automatic model_edge();
    int own_lock;
    int own_req;
    int peer_req;
    int nxt;
    if (bus.hready !== 1'b1) return;
    own_lock  = (m_owner == 1) ? int'(bus.hlock_1)   : int'(bus.hlock_2);
    own_req   = (m_owner == 1) ? int'(bus.hbusreq_1) : int'(bus.hbusreq_2);
    peer_req  = (m_owner == 1) ? int'(bus.hbusreq_2) : int'(bus.hbusreq_1);
    m_mlock   = own_lock;
    m_hmaster = m_owner - 1;
    if (own_lock != 0)                      nxt = m_owner;
    else if (own_req != 0 && m_beats < MAXB) nxt = m_owner;
    else if (peer_req != 0)                 nxt = 3 - m_owner;
    else if (own_req != 0)                  nxt = m_owner;
    else                                    nxt = DEF;
    if (nxt != m_owner) m_beats = 0;
    else if (bus.htrans >= 2) m_beats = (m_beats < MAXB) ? m_beats + 1 : MAXB;
    m_owner = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hgrant_1"},  32'(bus.hgrant_1),  32'(m_owner == 1));
    chk({tag, ".hgrant_2"},  32'(bus.hgrant_2),  32'(m_owner == 2));
    chk({tag, ".hmaster"},   32'(bus.hmaster),   32'(m_hmaster));
    chk({tag, ".hmastlock"}, 32'(bus.hmastlock), 32'(m_mlock));
    chk({tag, ".onehot"},    32'(bus.hgrant_1 + bus.hgrant_2), 32'd1);
  endtask

  task automatic cycle(input string tag);
    @(posedge hclk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic r1, input logic r2, input logic l1, input logic l2,
                       input logic [1:0] tr, input logic rdy);
    bus.hbusreq_1 = r1;
    bus.hbusreq_2 = r2;
    bus.hlock_1   = l1;
    bus.hlock_2   = l2;
    bus.htrans    = tr;
    bus.hready    = rdy;
  endtask

  initial begin
    int k;
    drive(0, 0, 0, 0, 2'b00, 1);
    model_reset();
    #1 hresetn = 1'b0;
    #2;
    chk("rst.hgrant_1",  32'(bus.hgrant_1),  32'd1);
    chk("rst.hgrant_2",  32'(bus.hgrant_2),  32'd0);
    chk("rst.hmaster",   32'(bus.hmaster),   32'd0);
    chk("rst.hmastlock", 32'(bus.hmastlock), 32'd0);
    #10 hresetn = 1'b1;

    // 1: idle after reset, parked on master 1
    for (int i = 0; i < 10; i++) cycle("t1_idle");

    // 2: master 2 requests alone, then releases
    drive(0, 1, 0, 0, 2'b10, 1);
    cycle("t2_req");
    chk("t2_grant2_after1", 32'(bus.hgrant_2), 32'd1);
    chk("t2_hmaster_lag",   32'(bus.hmaster),  32'd0);
    cycle("t2_own");
    chk("t2_hmaster_follow", 32'(bus.hmaster), 32'd1);
    drive(0, 0, 0, 0, 2'b00, 1);
    cycle("t2_drop");
    chk("t2_park_grant1", 32'(bus.hgrant_1), 32'd1);
    cycle("t2_park");
    chk("t2_park_hmaster", 32'(bus.hmaster), 32'd0);

    // 3: both request with back-to-back counted beats
    drive(1, 1, 0, 0, 2'b10, 1);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      cycle("t3_m1");
      k++;
      bus.htrans = 2'b11;
      if (bus.hgrant_2 === 1'b1) break;
    end
    chk("t3_edges_to_m2", 32'(k), 32'(MAXB + 1));
    k = 0;
    for (int i = 0; i < 20; i++) begin
      cycle("t3_m2");
      k++;
      if (bus.hgrant_1 === 1'b1) break;
    end
    chk("t3_edges_to_m1", 32'(k), 32'(MAXB + 1));

    // 4: master 1 holds a lock across 20 beats while master 2 waits
    drive(1, 1, 1, 0, 2'b11, 1);
    for (int i = 0; i < 20; i++) begin
      cycle("t4_lock");
      chk("t4_lock_grant1", 32'(bus.hgrant_1), 32'd1);
    end
    chk("t4_hmastlock", 32'(bus.hmastlock), 32'd1);
    bus.hlock_1 = 1'b0;
    cycle("t4_unlock");
    chk("t4_switch_m2", 32'(bus.hgrant_2), 32'd1);

    // 5: master 2 reaches its limit, then hready stalls at the switch point
    drive(1, 1, 0, 0, 2'b11, 1);
    for (int i = 0; i < MAXB; i++) cycle("t5_burst");
    bus.hready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("t5_stall");
      chk("t5_frozen_grant2",  32'(bus.hgrant_2), 32'd1);
      chk("t5_frozen_hmaster", 32'(bus.hmaster),  32'd1);
    end
    bus.hready = 1'b1;
    cycle("t5_release");
    chk("t5_switch_m1", 32'(bus.hgrant_1), 32'd1);

    // 6: reset lands mid-burst while master 2 owns the bus
    drive(0, 1, 0, 0, 2'b11, 1);
    for (int i = 0; i < 4; i++) cycle("t6_burst");
    chk("t6_m2_owns", 32'(bus.hgrant_2), 32'd1);
    #2 hresetn = 1'b0;
    model_reset();
    #1;
    chk("t6_async_hgrant_1",  32'(bus.hgrant_1),  32'd1);
    chk("t6_async_hgrant_2",  32'(bus.hgrant_2),  32'd0);
    chk("t6_async_hmaster",   32'(bus.hmaster),   32'd0);
    chk("t6_async_hmastlock", 32'(bus.hmastlock), 32'd0);
    #2 hresetn = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t6_after");

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
